// File: rtl/mac_postproc.sv
// mac_postproc: bias add, rounding requant shift, optional ReLU, signed
// saturation to OW bits, then a small first-word-fall-through output FIFO.
module mac_postproc #(
    parameter int DW         = 32,
    parameter int OW         = 8,
    parameter int SHW        = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] acc_in,
    input  logic          acc_vld,
    input  logic [DW-1:0] bias,
    input  logic [SHW-1:0] shift,
    input  logic          relu_en,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          fifo_full,
    output logic          drop,
    output logic [15:0]   sat_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Saturation bounds held at the intermediate width so compares stay signed.
    localparam logic signed [DW+1:0] MAXV = $signed((DW+2)'((1 << (OW-1)) - 1));
    localparam logic signed [DW+1:0] MINV = -MAXV - 1;

    // vld_pipe[1] = S1 holds a sum, vld_pipe[2] = S2 holds a quantized value
    logic [2:1]              vld_pipe;
    logic signed [DW:0]      sum_r;
    logic [SHW-1:0]          sh_r;
    logic                    relu1_r;
    logic signed [DW+1:0]    q_r;
    logic                    relu2_r;

    logic signed [DW+1:0]    sum_x, rnd, q_c;
    logic [OW-1:0]           y_c;
    logic                    sat_c;

    logic [OW-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           count;
    logic                    push, pop;

    // Valid shift register: the pipeline never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[1], acc_vld};
    end

    // S1: widen by one bit so acc+bias can never overflow; latch per-result config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= '0;
            sh_r    <= '0;
            relu1_r <= 1'b0;
        end else if (acc_vld) begin
            sum_r   <= $signed({acc_in[DW-1], acc_in}) + $signed({bias[DW-1], bias});
            sh_r    <= shift;
            relu1_r <= relu_en;
        end
    end

    // S2 datapath: add half an LSB of the result, then arithmetic shift (half-up).
    always_comb begin
        sum_x = {sum_r[DW], sum_r};
        rnd   = '0;
        if (sh_r != '0) rnd = $signed({{(DW+1){1'b0}}, 1'b1}) << (sh_r - 1'b1);
        q_c   = (sum_x + rnd) >>> sh_r;
    end

    // S2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r     <= '0;
            relu2_r <= 1'b0;
        end else if (vld_pipe[1]) begin
            q_r     <= q_c;
            relu2_r <= relu1_r;
        end
    end

    // S3: ReLU takes priority so clamped negatives are not counted as saturation.
    always_comb begin
        y_c   = q_r[OW-1:0];
        sat_c = 1'b0;
        if (relu2_r && q_r[DW+1]) begin
            y_c = '0;
        end else if (q_r > MAXV) begin
            y_c   = MAXV[OW-1:0];
            sat_c = 1'b1;
        end else if (q_r < MINV) begin
            y_c   = MINV[OW-1:0];
            sat_c = 1'b1;
        end
    end

    assign out_valid = (count != '0);
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = vld_pipe[2] & (~fifo_full | pop);

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= y_c;
    end

    // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag and saturating clamp counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop    <= 1'b0;
            sat_cnt <= '0;
        end else begin
            if (vld_pipe[2] && fifo_full && !pop) drop <= 1'b1;
            if (vld_pipe[2] && sat_c && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule
